shift_arbiter: RTL and testbench

- Shares one 32-bit shift datapath (SLL/SRL/SRA) between two requesters, A and B, in the ALU area of the register-bank design.
- Each requester has a valid/ready request channel and its own valid/ready response channel.
- Only one operation is in flight at a time.
- Arbitration is round-robin, or fixed priority to A, selected by a parameter.
- A 3-state FSM sequences accept, execute and respond.

---
 rtl/shift_arbiter_if.sv | 25 ++
 rtl/shift_arbiter.sv | 126 ++++++++++++
 tb/tb_shift_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// One requester's view of the shared shift unit: a request channel and its
// own response channel, both valid/ready.
interface shift_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, op, opa, opb, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, op, opa, opb, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter around one SLL/SRL/SRA datapath; accept -> exec -> respond,
// response valid 2 cycles after accept, held stable until the owner takes it.
module shift_arbiter #(
  parameter int DATA_W = 32,
  parameter bit FAIR   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_arbiter_if.slave   a,
  shift_arbiter_if.slave   b,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;
  logic              err_q;
  logic              a_rsp_vld;
  logic              b_rsp_vld;

  logic              gnt_b;
  logic              big;
  logic [4:0]        sh;
  logic [DATA_W-1:0] shift_res;
  logic              shift_err;

  // B wins only when alone, or on a fair tie when A went last.
  always_comb begin
    gnt_b = 1'b0;
    if (b.req_valid && !a.req_valid)
      gnt_b = 1'b1;
    else if (a.req_valid && b.req_valid)
      gnt_b = FAIR && !last_grant;
  end

  // rst_n gating keeps ready low while reset is held with a request pending.
  assign a.req_ready = rst_n && (state == IDLE) && a.req_valid && !gnt_b;
  assign b.req_ready = rst_n && (state == IDLE) && gnt_b;

  always_comb begin
    big       = |opb_q[DATA_W-1:5];
    sh        = opb_q[4:0];
    shift_res = '0;
    shift_err = 1'b0;
    case (op_q)
      2'b00:   shift_res = big ? '0 : (opa_q << sh);
      2'b01:   shift_res = big ? '0 : (opa_q >> sh);
      2'b10:   shift_res = big ? {DATA_W{opa_q[DATA_W-1]}}
                               : DATA_W'($signed(opa_q) >>> sh);
      default: shift_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      a_rsp_vld  <= 1'b0;
      b_rsp_vld  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a.req_ready) begin
            op_q       <= a.op;
            opa_q      <= a.opa;
            opb_q      <= a.opb;
            grant_id   <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (b.req_ready) begin
            op_q       <= b.op;
            opa_q      <= b.opa;
            opb_q      <= b.opb;
            grant_id   <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q <= shift_res;
          err_q <= shift_err;
          if (grant_id) b_rsp_vld <= 1'b1;
          else          a_rsp_vld <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          if ((a_rsp_vld && a.rsp_ready) || (b_rsp_vld && b.rsp_ready)) begin
            a_rsp_vld <= 1'b0;
            b_rsp_vld <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          a_rsp_vld <= 1'b0;
          b_rsp_vld <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign a.rsp_valid = a_rsp_vld;
  assign a.rsp_data  = res_q;
  assign a.rsp_err   = err_q;
  assign b.rsp_valid = b_rsp_vld;
  assign b.rsp_data  = res_q;
  assign b.rsp_err   = err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench: ch0/ch1 drive the round-robin instance, ch2/ch3 the fixed-priority one.
module tb_shift_arbiter;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [32:0] exp;   // {err, data}
  } req_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  shift_arbiter_if #(.DATA_W(32)) fa ();
  shift_arbiter_if #(.DATA_W(32)) fb ();
  shift_arbiter_if #(.DATA_W(32)) pa ();
  shift_arbiter_if #(.DATA_W(32)) pb ();
  logic busy_f, gid_f, busy_p, gid_p;

  shift_arbiter #(.DATA_W(32), .FAIR(1'b1)) dut_fair (
    .clk(clk), .rst_n(rst_n), .a(fa.slave), .b(fb.slave), .busy(busy_f), .grant_id(gid_f)
  );
  shift_arbiter #(.DATA_W(32), .FAIR(1'b0)) dut_pri (
    .clk(clk), .rst_n(rst_n), .a(pa.slave), .b(pb.slave), .busy(busy_p), .grant_id(gid_p)
  );

  logic        req_valid [4];
  logic        req_ready [4];
  logic [1:0]  op        [4];
  logic [31:0] opa       [4];
  logic [31:0] opb       [4];
  logic        rsp_valid [4];
  logic        rsp_ready [4];
  logic [31:0] rsp_data  [4];
  logic        rsp_err   [4];
  logic        gid       [4];

`define TB_CONN(IFN, N) \
  assign IFN.req_valid = req_valid[N]; \
  assign IFN.op        = op[N]; \
  assign IFN.opa       = opa[N]; \
  assign IFN.opb       = opb[N]; \
  assign IFN.rsp_ready = rsp_ready[N]; \
  assign req_ready[N]  = IFN.req_ready; \
  assign rsp_valid[N]  = IFN.rsp_valid; \
  assign rsp_data[N]   = IFN.rsp_data; \
  assign rsp_err[N]    = IFN.rsp_err;

  `TB_CONN(fa, 0)
  `TB_CONN(fb, 1)
  `TB_CONN(pa, 2)
  `TB_CONN(pb, 3)
`undef TB_CONN

  assign gid[0] = gid_f;
  assign gid[1] = gid_f;
  assign gid[2] = gid_p;
  assign gid[3] = gid_p;

  req_t        req_q [4][$];
  logic [32:0] exp_q [4][$];
  int          acc_cyc [4];
  bit          seen [4];
  bit          grant_log [2][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] s);
    logic [31:0] r;
    r = 32'h0;
    if (o == 2'b11) return {1'b1, 32'h0};
    if (s > 32'd31) r = (o == 2'b10 && x[31]) ? 32'hFFFF_FFFF : 32'h0;
    else begin
      for (int i = 0; i < 32; i++) begin
        case (o)
          2'b00:   r[i] = (i >= s) ? x[i - s] : 1'b0;
          2'b01:   r[i] = (i + s <= 31) ? x[i + s] : 1'b0;
          default: r[i] = (i + s <= 31) ? x[i + s] : x[31];
        endcase
      end
    end
    return {1'b0, r};
  endfunction

  function automatic req_t mk(input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] s, input logic [32:0] e);
    req_t r;
    r.op = o; r.opa = x; r.opb = s; r.exp = e;
    return r;
  endfunction

  // Driver + response monitor for all four channels.
  initial begin
    bit fire [4];
    for (int ch = 0; ch < 4; ch++) begin
      req_valid[ch] = 1'b0; op[ch] = 2'b0; opa[ch] = 32'h0; opb[ch] = 32'h0;
    end
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        fire[ch] = 1'b0;
        if (!rst_n) begin
          exp_q[ch].delete();
          seen[ch] = 1'b0;
        end else begin
          if (exp_q[ch].size() == 0)
            chk($sformatf("idle_rsp_valid_ch%0d", ch), 64'(rsp_valid[ch]), 64'd0);
          else if (rsp_valid[ch]) begin
            if (!seen[ch]) begin
              chk($sformatf("latency_ch%0d", ch), 64'(cyc - acc_cyc[ch]), 64'd2);
              seen[ch] = 1'b1;
            end
            chk($sformatf("rsp_ch%0d", ch), 64'({rsp_err[ch], rsp_data[ch]}), 64'(exp_q[ch][0]));
            chk($sformatf("grant_id_ch%0d", ch), 64'(gid[ch]), 64'(ch % 2));
            if (rsp_ready[ch]) begin
              void'(exp_q[ch].pop_front());
              seen[ch] = 1'b0;
            end
          end
          fire[ch] = req_valid[ch] && req_ready[ch];
          if (fire[ch]) begin
            exp_q[ch].push_back(req_q[ch][0].exp);
            grant_log[ch / 2].push_back(1'(ch % 2));
            acc_cyc[ch] = cyc;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 4; ch++) begin
        if (fire[ch]) void'(req_q[ch].pop_front());
        if (req_q[ch].size() > 0) begin
          req_valid[ch] = 1'b1;
          op[ch]  = req_q[ch][0].op;
          opa[ch] = req_q[ch][0].opa;
          opb[ch] = req_q[ch][0].opb;
        end else begin
          req_valid[ch] = 1'b0;
        end
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    bit empty;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      empty = 1'b1;
      for (int ch = 0; ch < 4; ch++)
        if (req_q[ch].size() != 0 || exp_q[ch].size() != 0) empty = 1'b0;
    end while (!empty && n < budget);
    if (!empty) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x, s;
    int n;
    for (int ch = 0; ch < 4; ch++) rsp_ready[ch] = 1'b1;

    // Contention from reset: both requesters of each instance hold 4 ops.
    for (int i = 0; i < 4; i++)
      for (int ch = 0; ch < 4; ch++) begin
        o = 2'($urandom_range(0, 2));
        x = $urandom;
        s = 32'($urandom_range(0, 40));
        req_q[ch].push_back(mk(o, x, s, model(o, x, s)));
      end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      64'(busy_f),       64'd0);
    chk("rst_grant_id",  64'(gid_f),        64'd0);
    chk("rst_a_rsp_vld", 64'(rsp_valid[0]), 64'd0);
    chk("rst_b_rsp_vld", 64'(rsp_valid[1]), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data[0]),  64'd0);
    chk("rst_rsp_err",   64'(rsp_err[0]),   64'd0);
    chk("rst_a_rdy",     64'(req_ready[0]), 64'd0);
    chk("rst_b_rdy",     64'(req_ready[1]), 64'd0);
    rst_n = 1'b1;
    drain(300);

    chk("fair_grants", 64'(grant_log[0].size()), 64'd8);
    chk("pri_grants",  64'(grant_log[1].size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fair_order_%0d", i), 64'(grant_log[0][i]), 64'(i % 2));
      chk($sformatf("pri_order_%0d", i),  64'(grant_log[1][i]), 64'(i >= 4));
    end

    // Directed values on the round-robin instance.
    req_q[0].push_back(mk(2'b00, 32'h0000_0001, 32'd4, 33'h0_0000_0010));
    drain(50);
    req_q[0].push_back(mk(2'b00, 32'hFFFF_FFFF, 32'd31,   33'h0_8000_0000));
    req_q[0].push_back(mk(2'b00, 32'hFFFF_FFFF, 32'd32,   33'h0_0000_0000));
    req_q[1].push_back(mk(2'b01, 32'h8000_0000, 32'd31,   33'h0_0000_0001));
    req_q[1].push_back(mk(2'b10, 32'h8000_0000, 32'd35,   33'h0_FFFF_FFFF));
    req_q[1].push_back(mk(2'b10, 32'h4000_0000, 32'h100,  33'h0_0000_0000));
    req_q[1].push_back(mk(2'b11, 32'h0000_1234, 32'd5,    33'h1_0000_0000));
    drain(100);

    // Backpressure on B while A waits.
    rsp_ready[1] = 1'b0;
    req_q[1].push_back(mk(2'b00, 32'h1234_5678, 32'd0, 33'h0_1234_5678));
    n = 0;
    while (!busy_f && n < 20) begin @(negedge clk); n++; end
    chk("bp_b_accept", 64'(busy_f), 64'd1);
    req_q[0].push_back(mk(2'b01, 32'h0000_0100, 32'd4, 33'h0_0000_0010));
    n = 0;
    while (!rsp_valid[1] && n < 20) begin @(negedge clk); n++; end
    chk("bp_b_rsp_vld", 64'(rsp_valid[1]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_b_hold_vld", 64'(rsp_valid[1]), 64'd1);
      chk("bp_b_hold_dat", 64'(rsp_data[1]),  64'h1234_5678);
      chk("bp_a_rdy_low",  64'(req_ready[0]), 64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_a_accept", 64'(req_ready[0]), 64'd1);
    drain(50);

    // Reset while in EXEC: the accepted op vanishes, the other completes later.
    req_q[0].push_back(mk(2'b00, 32'h0000_0001, 32'd1, 33'h0_0000_0002));
    req_q[1].push_back(mk(2'b01, 32'h0000_0006, 32'd1, 33'h0_0000_0003));
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(busy_f && !rsp_valid[0] && !rsp_valid[1]) && n < 20);
    chk("exec_reached", 64'(busy_f), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(busy_f),       64'd0);
    chk("mid_rst_a_rdy", 64'(req_ready[0]), 64'd0);
    chk("mid_rst_b_rdy", 64'(req_ready[1]), 64'd0);
    chk("mid_rst_a_vld", 64'(rsp_valid[0]), 64'd0);
    chk("mid_rst_b_vld", 64'(rsp_valid[1]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(50);
    req_q[0].push_back(mk(2'b10, 32'hF000_0000, 32'd4, 33'h0_FF00_0000));
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
